// File: rtl/regfile_writeback_queue.sv
// Write-side front end of the register file.
// Merges the in-order pipeline writeback (WB, always first) with results from the
// long-latency unit (LU), which wait in a small FIFO. A later WB write to the same
// register marks queued LU entries as killed, so a stale LU value never overwrites a
// newer one. A per-register pending mask lets the hazard unit stall readers.
//
// Handshake: the LU offers a result with lu_valid. It is pushed at the posedge where
// lu_valid && lu_ready. lu_ready depends only on occupancy and rst, never on lu_valid,
// and it stays low while full even if a pop happens in the same cycle.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_regWrite,
    input  logic [ADDR_W-1:0]        wb_writeReg,
    input  logic [DATA_W-1:0]        wb_writeData,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [ADDR_W-1:0]        lu_writeReg,
    input  logic [DATA_W-1:0]        lu_writeData,
    output logic                     regWrite,
    output logic [ADDR_W-1:0]        writeReg,
    output logic [DATA_W-1:0]        writeData,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // FIFO storage: data, destination register, kill flag per slot
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [ADDR_W-1:0] dst_q  [DEPTH];
    logic [ADDR_W-1:0] dst_d  [DEPTH];
    logic [DEPTH-1:0]  kill_q;
    logic [DEPTH-1:0]  kill_d;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    // Registered write port towards the register file
    logic              regWrite_q,  regWrite_d;
    logic [ADDR_W-1:0] writeReg_q,  writeReg_d;
    logic [DATA_W-1:0] writeData_q, writeData_d;

    logic [DEPTH-1:0]  slot_valid;
    logic              wb_do;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              head_kill;
    logic              push_kill;

    // A WB write to r0 is treated as idle
    assign wb_do      = wb_regWrite && (wb_writeReg != '0);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign lu_ready   = !fifo_full && !rst;
    assign push       = lu_valid && lu_ready;
    assign pop        = !wb_do && !fifo_empty;
    assign head_kill  = kill_q[rd_ptr_q];
    // Entry born dead: targets r0, or the same register WB writes at this very edge
    assign push_kill  = (lu_writeReg == '0) ||
                        (wb_do && (lu_writeReg == wb_writeReg));

    // Mark which slots hold queued entries (distance from read pointer < count)
    always_comb begin
        slot_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
        end
    end

    // FIFO next state: WAW kills, push, pop, occupancy
    always_comb begin
        data_d   = data_q;
        dst_d    = dst_q;
        kill_d   = kill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wb_do) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_valid[i] && (dst_q[i] == wb_writeReg)) begin
                    kill_d[i] = 1'b1;
                end
            end
        end

        // Push slot is never a valid slot because pushes are refused when full
        if (push) begin
            data_d[wr_ptr_q] = lu_writeData;
            dst_d[wr_ptr_q]  = lu_writeReg;
            kill_d[wr_ptr_q] = push_kill;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Select what goes to the register-file port: WB first, then live FIFO head
    always_comb begin
        regWrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        if (wb_do) begin
            regWrite_d  = 1'b1;
            writeReg_d  = wb_writeReg;
            writeData_d = wb_writeData;
        end else if (pop && !head_kill) begin
            regWrite_d  = 1'b1;
            writeReg_d  = dst_q[rd_ptr_q];
            writeData_d = data_q[rd_ptr_q];
        end
    end

    // Pending mask: one-hot destinations of queued, non-killed entries
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && !kill_q[i]) begin
                pending = pending | (32'(1) << dst_q[i]);
            end
        end
        pending[0] = 1'b0;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                dst_q[i]  <= '0;
            end
            kill_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
        end else begin
            data_q      <= data_d;
            dst_q       <= dst_d;
            kill_q      <= kill_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
        end
    end

    assign regWrite  = regWrite_q;
    assign writeReg  = writeReg_q;
    assign writeData = writeData_q;
    assign count     = count_q;

endmodule
